uart_frame_engine: RTL and testbench

Parametrised idle-timeout framer and responder for the UART byte path. It collects bytes from the uart_rx byte interface into a frame buffer, closes the frame after a configurable silence, appends a configurable terminator, then either echoes the frame through the uart_tx byte interface or holds it for host readout/transmit. It sits between uart_rx/uart_tx and the application logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/frame_buf.sv | 28 ++
 rtl/uart_frame_engine.sv | 198 +++++++++++++++++++
 tb/tb_uart_frame_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame engine: FSM states, default terminator, width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    TERM,
    SEND,
    HOLD
  } state_t;

  localparam logic [7:0] TERM_BYTE_DEF = 8'h26;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Frame buffer: DEPTH x 8 RAM, one synchronous write port, two synchronous read ports
// (transmit path and host readout path).
module frame_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] tx_addr,
  output logic [7:0]    tx_q,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_q
);

  logic [7:0] mem [DEPTH];

  // Write when enabled; both read ports return the pre-write contents one cycle later.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    tx_q <= mem[tx_addr];
    rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_engine.sv
// Idle-timeout framer: gathers rx bytes into a frame, closes it after a silence,
// appends terminator bytes, then echoes the frame or holds it for the host.
module uart_frame_engine
  import uart_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         IDLE_US   = 1000,
  parameter int         DEPTH     = 64,
  parameter int         TERM_LEN  = 2,
  parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEF,
  parameter int         ECHO      = 1,
  localparam int        AW        = clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_vld,
  output logic [7:0]    tx_data,
  output logic          tx_req,
  input  logic          tx_done,
  output logic          frm_valid,
  output logic [AW:0]   frm_len,
  output logic          frm_ovf,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frm_ack,
  input  logic          tx_start,
  output logic          frm_sent,
  output logic          rx_drop
);

  localparam int            IDLE_CLKS   = CLK_HZ / 1_000_000 * IDLE_US;
  localparam int            CW          = (clog2(IDLE_CLKS) < 1) ? 1 : clog2(IDLE_CLKS);
  localparam logic [CW-1:0] IDLE_LAST   = CW'(IDLE_CLKS - 1);
  localparam logic [AW:0]   PAYLOAD_MAX = (AW + 1)'(DEPTH - TERM_LEN);
  localparam logic [AW:0]   LEN_ONE     = (AW + 1)'(1);

  if (TERM_LEN < 0 || TERM_LEN > 2 || DEPTH < 4 || DEPTH > 256 ||
      (DEPTH & (DEPTH - 1)) != 0 || IDLE_CLKS < 1) begin : g_param_check
    $error("uart_frame_engine: illegal parameter set");
  end

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic [1:0]    term_cnt;
  logic [AW-1:0] tx_idx;
  logic          tx_pend;   // buffer read issued, byte goes out next cycle
  logic          tx_wait;   // byte handed to uart_tx, waiting for tx_done

  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [AW-1:0] tx_addr;
  logic [7:0]    tx_q;

  logic last_byte;
  logic payload_ok;
  logic term_done;
  logic tx_advance;

  assign last_byte  = ({1'b0, tx_idx} + LEN_ONE) == frm_len;
  assign payload_ok = frm_len < PAYLOAD_MAX;
  assign term_done  = int'(term_cnt) >= TERM_LEN - 1;
  assign tx_advance = tx_wait && tx_done && !last_byte;

  frame_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_buf (
    .sys_clk (sys_clk),
    .wr_en   (buf_we),
    .wr_addr (buf_waddr),
    .wr_data (buf_wdata),
    .tx_addr (tx_addr),
    .tx_q    (tx_q),
    .rd_addr (rd_addr),
    .rd_q    (rd_data)
  );

  // Buffer write port and look-ahead transmit read address; outside SEND the read
  // address parks on 0 so the first byte is ready as soon as SEND is entered.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = frm_len[AW-1:0];
    buf_wdata = rx_data;
    tx_addr   = '0;
    case (state)
      IDLE: begin
        buf_we    = rx_vld;
        buf_waddr = '0;
      end
      RECV: buf_we = rx_vld && payload_ok;
      TERM: begin
        buf_we    = 1'b1;
        buf_wdata = TERM_BYTE;
      end
      SEND: tx_addr = tx_advance ? tx_idx + AW'(1) : tx_idx;
      default: ;
    endcase
  end

  // Frame FSM with registered outputs and transmit handshake.
  always_ff @(posedge sys_clk) begin
    tx_req   <= 1'b0;
    frm_sent <= 1'b0;
    rx_drop  <= 1'b0;
    if (sys_rst) begin
      state     <= IDLE;
      frm_valid <= 1'b0;
      frm_ovf   <= 1'b0;
      frm_len   <= '0;
      tx_data   <= '0;
      idle_cnt  <= '0;
      term_cnt  <= '0;
      tx_idx    <= '0;
      tx_pend   <= 1'b0;
      tx_wait   <= 1'b0;
    end else begin
      if (rx_vld && (state == TERM || state == SEND || state == HOLD)) rx_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (rx_vld) begin
            frm_len  <= LEN_ONE;
            frm_ovf  <= 1'b0;
            idle_cnt <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (rx_vld) begin
            idle_cnt <= '0;
            if (payload_ok) frm_len <= frm_len + LEN_ONE;
            else            frm_ovf <= 1'b1;
          end else if (idle_cnt == IDLE_LAST) begin
            term_cnt <= '0;
            tx_idx   <= '0;
            if (TERM_LEN != 0) begin
              state <= TERM;
            end else if (ECHO != 0) begin
              state   <= SEND;
              tx_pend <= 1'b1;
            end else begin
              state     <= HOLD;
              frm_valid <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        TERM: begin
          frm_len  <= frm_len + LEN_ONE;
          term_cnt <= term_cnt + 2'd1;
          if (term_done) begin
            if (ECHO != 0) begin
              state   <= SEND;
              tx_pend <= 1'b1;
            end else begin
              state     <= HOLD;
              frm_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (tx_start) begin
            state   <= SEND;
            tx_idx  <= '0;
            tx_pend <= 1'b1;
          end else if (frm_ack) begin
            state     <= IDLE;
            frm_len   <= '0;
            frm_valid <= 1'b0;
          end
        end
        SEND: begin
          if (tx_pend) begin
            tx_req  <= 1'b1;
            tx_data <= tx_q;
            tx_pend <= 1'b0;
            tx_wait <= 1'b1;
          end else if (tx_wait && tx_done) begin
            tx_wait <= 1'b0;
            if (last_byte) begin
              frm_sent  <= 1'b1;
              frm_valid <= 1'b0;
              frm_len   <= '0;
              state     <= IDLE;
            end else begin
              tx_idx  <= tx_idx + AW'(1);
              tx_pend <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_engine.sv
// Directed bench for uart_frame_engine: one echo instance and one hold instance
// (DEPTH=8, TERM_LEN=2, IDLE_CLKS=100), selected through a shared stimulus bus.
module tb_uart_frame_engine;

  localparam int AW = 3;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic          sys_rst;
  logic          sel;
  logic [7:0]    rx_data;
  logic          rx_vld, tx_done, frm_ack, tx_start;
  logic [AW-1:0] rd_addr;

  logic [7:0] e_tx_data, e_rd_data, h_tx_data, h_rd_data;
  logic       e_tx_req, e_frm_valid, e_frm_ovf, e_frm_sent, e_rx_drop;
  logic       h_tx_req, h_frm_valid, h_frm_ovf, h_frm_sent, h_rx_drop;
  logic [AW:0] e_frm_len, h_frm_len;
  logic       e_rx_vld, e_tx_done, e_frm_ack, e_tx_start;
  logic       h_rx_vld, h_tx_done, h_frm_ack, h_tx_start;

  logic [7:0]  tx_data, rd_data;
  logic        tx_req, frm_valid, frm_ovf, frm_sent, rx_drop;
  logic [AW:0] frm_len;

  assign e_rx_vld   = rx_vld   & ~sel;
  assign e_tx_done  = tx_done  & ~sel;
  assign e_frm_ack  = frm_ack  & ~sel;
  assign e_tx_start = tx_start & ~sel;
  assign h_rx_vld   = rx_vld   & sel;
  assign h_tx_done  = tx_done  & sel;
  assign h_frm_ack  = frm_ack  & sel;
  assign h_tx_start = tx_start & sel;

  assign tx_data   = sel ? h_tx_data   : e_tx_data;
  assign rd_data   = sel ? h_rd_data   : e_rd_data;
  assign tx_req    = sel ? h_tx_req    : e_tx_req;
  assign frm_valid = sel ? h_frm_valid : e_frm_valid;
  assign frm_ovf   = sel ? h_frm_ovf   : e_frm_ovf;
  assign frm_sent  = sel ? h_frm_sent  : e_frm_sent;
  assign rx_drop   = sel ? h_rx_drop   : e_rx_drop;
  assign frm_len   = sel ? h_frm_len   : e_frm_len;

  uart_frame_engine #(
    .CLK_HZ(1_000_000), .IDLE_US(100), .DEPTH(8), .TERM_LEN(2), .TERM_BYTE(8'h26), .ECHO(1)
  ) u_echo (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_vld(e_rx_vld),
    .tx_data(e_tx_data), .tx_req(e_tx_req), .tx_done(e_tx_done), .frm_valid(e_frm_valid),
    .frm_len(e_frm_len), .frm_ovf(e_frm_ovf), .rd_addr(rd_addr), .rd_data(e_rd_data),
    .frm_ack(e_frm_ack), .tx_start(e_tx_start), .frm_sent(e_frm_sent), .rx_drop(e_rx_drop)
  );

  uart_frame_engine #(
    .CLK_HZ(1_000_000), .IDLE_US(100), .DEPTH(8), .TERM_LEN(2), .TERM_BYTE(8'h26), .ECHO(0)
  ) u_hold (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_data(rx_data), .rx_vld(h_rx_vld),
    .tx_data(h_tx_data), .tx_req(h_tx_req), .tx_done(h_tx_done), .frm_valid(h_frm_valid),
    .frm_len(h_frm_len), .frm_ovf(h_frm_ovf), .rd_addr(rd_addr), .rd_data(h_rd_data),
    .frm_ack(h_frm_ack), .tx_start(h_tx_start), .frm_sent(h_frm_sent), .rx_drop(h_rx_drop)
  );

  int n_run = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int sent_cnt = 0;
  logic [AW:0] len_at_req;
  logic        ovf_at_req;
  logic [7:0]  exp_b [8];

  always @(negedge sys_clk) begin
    if (tx_req)   req_cnt++;
    if (frm_sent) sent_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge sys_clk);
    rx_vld  = 1'b0;
  endtask

  // Acts as uart_tx for one byte: waits for tx_req, checks it, then returns tx_done.
  task automatic serve_byte(input string tag, input logic [7:0] exp, input bit first,
                            input bit last, input bit inject);
    int w;
    w = 0;
    while (!tx_req && w < 400) begin
      @(negedge sys_clk);
      w++;
    end
    if (!tx_req) begin
      check({tag, " req timeout"}, 32'(tx_req), 32'd1);
      return;
    end
    if (first) begin
      len_at_req = frm_len;
      ovf_at_req = frm_ovf;
    end else begin
      check({tag, " req latency"}, 32'(w), 32'd1);
    end
    check({tag, " data"}, 32'(tx_data), 32'(exp));
    @(negedge sys_clk);
    check({tag, " req pulse"}, 32'(tx_req), 32'd0);
    if (inject) begin
      rx_data = 8'hEE;
      rx_vld  = 1'b1;
      @(negedge sys_clk);
      rx_vld  = 1'b0;
      check({tag, " rx_drop in SEND"}, 32'(rx_drop), 32'd1);
    end else begin
      @(negedge sys_clk);
    end
    check({tag, " data held"}, 32'(tx_data), 32'(exp));
    tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    if (last) begin
      check({tag, " frm_sent"}, 32'(frm_sent), 32'd1);
      @(negedge sys_clk);
      check({tag, " frm_sent pulse"}, 32'(frm_sent), 32'd0);
      check({tag, " frm_len cleared"}, 32'(frm_len), 32'd0);
    end
  endtask

  task automatic serve_frame(input string tag, input int n);
    for (int i = 0; i < n; i++)
      serve_byte($sformatf("%s[%0d]", tag, i), exp_b[i], i == 0, i == n - 1, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    int w;
    w = 0;
    while (!frm_valid && w < 400) begin
      @(negedge sys_clk);
      w++;
    end
    check({tag, " frm_valid"}, 32'(frm_valid), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0;
    logic [7:0] rd_exp [4];
    sys_rst = 1'b1; sel = 1'b0; rx_data = '0; rx_vld = 1'b0; tx_done = 1'b0;
    frm_ack = 1'b0; tx_start = 1'b0; rd_addr = '0;
    repeat (3) @(negedge sys_clk);

    // Reset values on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("rst%0d tx_req", s),    32'(tx_req),    32'd0);
      check($sformatf("rst%0d frm_valid", s), 32'(frm_valid), 32'd0);
      check($sformatf("rst%0d frm_ovf", s),   32'(frm_ovf),   32'd0);
      check($sformatf("rst%0d frm_sent", s),  32'(frm_sent),  32'd0);
      check($sformatf("rst%0d rx_drop", s),   32'(rx_drop),   32'd0);
      check($sformatf("rst%0d frm_len", s),   32'(frm_len),   32'd0);
      check($sformatf("rst%0d tx_data", s),   32'(tx_data),   32'd0);
    end
    sel = 1'b0;
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Echo "ABC" plus two terminators
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    check("abc frm_len", 32'(frm_len), 32'd3);
    check("abc frm_ovf", 32'(frm_ovf), 32'd0);
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43; exp_b[3] = 8'h26; exp_b[4] = 8'h26;
    r0 = req_cnt; s0 = sent_cnt;
    serve_frame("abc", 5);
    check("abc len at send", 32'(len_at_req), 32'd5);
    repeat (5) @(negedge sys_clk);
    check("abc req count", 32'(req_cnt - r0), 32'd5);
    check("abc sent count", 32'(sent_cnt - s0), 32'd1);

    // Overflow: 10 bytes into an 8-byte buffer with 2 terminator slots reserved
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    check("ovf frm_len", 32'(frm_len), 32'd6);
    check("ovf frm_ovf", 32'(frm_ovf), 32'd1);
    for (int i = 0; i < 6; i++) exp_b[i] = 8'(i);
    exp_b[6] = 8'h26; exp_b[7] = 8'h26;
    serve_frame("ovf", 8);
    check("ovf len at send", 32'(len_at_req), 32'd8);
    check("ovf flag at send", 32'(ovf_at_req), 32'd1);

    // Second byte lands exactly in the counter==99 cycle: same frame
    send_byte(8'h11);
    repeat (98) @(negedge sys_clk);
    send_byte(8'h22);
    check("idle99 frm_len", 32'(frm_len), 32'd2);
    check("idle99 frm_ovf cleared", 32'(frm_ovf), 32'd0);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h26; exp_b[3] = 8'h26;
    serve_frame("idle99", 4);
    check("idle99 len at send", 32'(len_at_req), 32'd4);

    // One cycle later: frame already closed, byte dropped, next byte a new frame
    send_byte(8'h33);
    repeat (99) @(negedge sys_clk);
    send_byte(8'h44);
    check("idle100 rx_drop", 32'(rx_drop), 32'd1);
    exp_b[0] = 8'h33; exp_b[1] = 8'h26; exp_b[2] = 8'h26;
    serve_frame("idle100a", 3);
    check("idle100a len at send", 32'(len_at_req), 32'd3);
    send_byte(8'h55);
    exp_b[0] = 8'h55;
    serve_frame("idle100b", 3);
    check("idle100b len at send", 32'(len_at_req), 32'd3);

    // Hold mode: "HI", host readout, ack without transmit
    sel = 1'b1;
    #1;
    r0 = req_cnt;
    send_byte(8'h48); send_byte(8'h49);
    wait_valid("hold");
    check("hold frm_len", 32'(frm_len), 32'd4);
    rd_exp[0] = 8'h48; rd_exp[1] = 8'h49; rd_exp[2] = 8'h26; rd_exp[3] = 8'h26;
    for (int a = 0; a < 4; a++) begin
      @(negedge sys_clk);
      rd_addr = AW'(a);
      @(negedge sys_clk);
      check($sformatf("hold rd[%0d]", a), 32'(rd_data), 32'(rd_exp[a]));
    end
    @(negedge sys_clk);
    rd_addr = '0;
    check("hold rd latency", 32'(rd_data), 32'h26);
    @(negedge sys_clk);
    check("hold rd[0] again", 32'(rd_data), 32'h48);
    frm_ack = 1'b1;
    @(negedge sys_clk);
    frm_ack = 1'b0;
    check("hold ack frm_valid", 32'(frm_valid), 32'd0);
    check("hold ack frm_len", 32'(frm_len), 32'd0);
    repeat (10) @(negedge sys_clk);
    check("hold no tx_req", 32'(req_cnt - r0), 32'd0);

    // Hold mode: tx_start and frm_ack together, transmit wins
    send_byte(8'h5A); send_byte(8'h5B);
    wait_valid("start");
    @(negedge sys_clk);
    tx_start = 1'b1; frm_ack = 1'b1;
    @(negedge sys_clk);
    tx_start = 1'b0; frm_ack = 1'b0;
    check("start ack ignored", 32'(frm_len), 32'd4);
    exp_b[0] = 8'h5A; exp_b[1] = 8'h5B; exp_b[2] = 8'h26; exp_b[3] = 8'h26;
    serve_frame("start", 4);
    check("start len at send", 32'(len_at_req), 32'd4);
    check("start frm_valid after send", 32'(frm_valid), 32'd0);

    // Reset in the middle of an echo, after the 2nd tx_done
    sel = 1'b0;
    #1;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    serve_byte("mid[0]", 8'hA1, 1'b1, 1'b0, 1'b0);
    serve_byte("mid[1]", 8'hA2, 1'b0, 1'b0, 1'b0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("mid rst tx_req", 32'(tx_req), 32'd0);
    check("mid rst tx_data", 32'(tx_data), 32'd0);
    check("mid rst frm_len", 32'(frm_len), 32'd0);
    check("mid rst frm_valid", 32'(frm_valid), 32'd0);
    check("mid rst frm_sent", 32'(frm_sent), 32'd0);
    sys_rst = 1'b0;
    r0 = req_cnt;
    @(negedge sys_clk);
    tx_done = 1'b1;
    @(negedge sys_clk);
    tx_done = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("stray done no tx_req", 32'(req_cnt - r0), 32'd0);
    check("stray done frm_len", 32'(frm_len), 32'd0);
    send_byte(8'h77);
    check("clean frm_len", 32'(frm_len), 32'd1);
    check("clean frm_ovf", 32'(frm_ovf), 32'd0);
    serve_byte("clean[0]", 8'h77, 1'b1, 1'b0, 1'b1);
    serve_byte("clean[1]", 8'h26, 1'b0, 1'b0, 1'b0);
    serve_byte("clean[2]", 8'h26, 1'b0, 1'b1, 1'b0);
    check("clean len at send", 32'(len_at_req), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
